gate_sweep_ctrl: RTL and testbench



---
 rtl/gate_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive self-check sequencer for a small combinational gate: sweeps all input
// vectors, holds each HOLD_CYCLES cycles, samples and compares against EXPECTED.
// Optional macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_sweep_ctrl #(
    parameter int                     N_IN        = 2,
    parameter int                     HOLD_CYCLES = 4,
    parameter logic [(2**N_IN)-1:0]   EXPECTED    = 4'b0111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              dut_out,
    output logic [N_IN-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
);

    localparam int N_VEC = 2**N_IN;
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(N_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic              fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
    logic              pass_q, pass_d;
    logic              mismatch;
    logic              stop;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        vec_d        = vec_q;
        hold_d       = hold_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        pass_d       = pass_q;
        mismatch     = (dut_out != EXPECTED[vec_q]);
        stop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_DRIVE;
                    vec_d        = '0;
                    hold_d       = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    pass_d       = 1'b0;
                end
            end

            S_DRIVE: begin
                if (abort) begin
                    // Abort beats a coinciding sample; partial results are kept.
                    state_d = S_IDLE;
                    vec_d   = '0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        err_count_d = err_count_q + (N_IN+1)'(1);
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = vec_q;
                        end
                    end
`ifdef SWEEP_STOP_ON_FAIL_EN
                    stop = (vec_q == VEC_LAST) || mismatch;
`else
                    stop = (vec_q == VEC_LAST);
`endif
                    hold_d = '0;
                    if (stop) begin
                        state_d = S_DONE;
                        vec_d   = '0;
                        pass_d  = (err_count_d == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            hold_q       <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            hold_q       <= hold_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            pass_q       <= pass_d;
        end
    end

    assign busy       = (state_q == S_DRIVE);
    assign done       = (state_q == S_DONE);
    assign dut_in     = busy ? vec_q : '0;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed self-checking bench for gate_sweep_ctrl: pass, all-fail, stuck-at,
// abort, ignored restart, mid-sweep reset and a HOLD_CYCLES=1 instance.
module tb_gate_sweep_ctrl;

    localparam int GATE_NAND   = 0;
    localparam int GATE_AND    = 1;
    localparam int GATE_STUCK1 = 2;

    logic       clk;
    logic       rst_n;
    logic       start, abort;
    logic       dut_out;
    logic [1:0] dut_in;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] fail_vec;

    logic       start1;
    logic       dut_out1;
    logic [1:0] dut_in1;
    logic       busy1, done1, pass1, fail_valid1;
    logic [2:0] err_count1;
    logic [1:0] fail_vec1;

    int gate_mode;
    int n_checks;
    int n_errors;

    gate_sweep_ctrl #(.N_IN(2), .HOLD_CYCLES(4), .EXPECTED(4'b0111)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
        .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    gate_sweep_ctrl #(.N_IN(2), .HOLD_CYCLES(1), .EXPECTED(4'b0111)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .dut_out(dut_out1),
        .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .fail_valid(fail_valid1), .fail_vec(fail_vec1)
    );

    // Gate models attached to the sequencers.
    always_comb begin
        dut_out = 1'b0;
        case (gate_mode)
            GATE_NAND:   dut_out = ~(dut_in[1] & dut_in[0]);
            GATE_AND:    dut_out = dut_in[1] & dut_in[0];
            GATE_STUCK1: dut_out = 1'b1;
            default:     dut_out = 1'b0;
        endcase
    end
    assign dut_out1 = ~(dut_in1[1] & dut_in1[0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input logic [2:0] e_err,
                                 input logic e_fv, input logic [1:0] e_fvec, input logic e_pass);
        check({tag, ".err_count"},  32'(err_count),  32'(e_err));
        check({tag, ".fail_valid"}, 32'(fail_valid), 32'(e_fv));
        check({tag, ".fail_vec"},   32'(fail_vec),   32'(e_fvec));
        check({tag, ".pass"},       32'(pass),       32'(e_pass));
    endtask

    // Start at edge 0, then walk cycles 1..last_busy+1 checking busy/done/dut_in,
    // optionally re-pulsing start during cycle restart_cycle.
    task automatic run_sweep(input string tag, input int last_busy, input int restart_cycle,
                             input logic [2:0] e_err, input logic e_fv,
                             input logic [1:0] e_fvec, input logic e_pass);
        logic [1:0] e_in;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= last_busy + 1; k++) begin
            e_in = (k <= last_busy) ? 2'((k - 1) / 4) : 2'b00;
            check($sformatf("%s.busy@%0d", tag, k),   32'(busy),   32'(k <= last_busy));
            check($sformatf("%s.done@%0d", tag, k),   32'(done),   32'(k == last_busy + 1));
            check($sformatf("%s.dut_in@%0d", tag, k), 32'(dut_in), 32'(e_in));
            if (k == last_busy + 1) check_results(tag, e_err, e_fv, e_fvec, e_pass);
            start = (k == restart_cycle);
            tick();
        end
        start = 1'b0;
        check({tag, ".idle_busy"}, 32'(busy), 32'(0));
        check({tag, ".idle_done"}, 32'(done), 32'(0));
        check_results({tag, ".held"}, e_err, e_fv, e_fvec, e_pass);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        gate_mode = GATE_NAND;
        rst_n     = 1'b0;
        start     = 1'b0;
        start1    = 1'b0;
        abort     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst.busy",   32'(busy),   32'(0));
        check("rst.done",   32'(done),   32'(0));
        check("rst.dut_in", 32'(dut_in), 32'(0));
        check_results("rst", 3'd0, 1'b0, 2'b00, 1'b0);

        // Correct NAND: busy cycles 1-16, done in 17, pass
        run_sweep("nand", 16, -1, 3'd0, 1'b0, 2'b00, 1'b1);

        // AND attached: every vector mismatches
        gate_mode = GATE_AND;
`ifdef SWEEP_STOP_ON_FAIL_EN
        run_sweep("and", 4, -1, 3'd1, 1'b1, 2'b00, 1'b0);
`else
        run_sweep("and", 16, -1, 3'd4, 1'b1, 2'b00, 1'b0);
`endif

        // Output stuck at 1: only vector 11 mismatches
        gate_mode = GATE_STUCK1;
`ifdef SWEEP_STOP_ON_FAIL_EN
        run_sweep("stuck1", 16, -1, 3'd1, 1'b1, 2'b11, 1'b0);
`else
        run_sweep("stuck1", 16, -1, 3'd1, 1'b1, 2'b11, 1'b0);
`endif

        // Abort during cycle 6 (vector 01)
        gate_mode = GATE_NAND;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort.pre_dut_in", 32'(dut_in), 32'(2'b01));
        check("abort.pre_pass",   32'(pass),   32'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy",   32'(busy),   32'(0));
        check("abort.dut_in", 32'(dut_in), 32'(0));
        check("abort.done",   32'(done),   32'(0));
        for (int k = 0; k < 12; k++) begin
            check($sformatf("abort.no_done@%0d", k), 32'(done), 32'(0));
            tick();
        end
        check_results("abort", 3'd0, 1'b0, 2'b00, 1'b0);
        run_sweep("after_abort", 16, -1, 3'd0, 1'b0, 2'b00, 1'b1);

        // start re-pulsed in cycle 8 is ignored
        run_sweep("restart", 16, 8, 3'd0, 1'b0, 2'b00, 1'b1);
        check("restart.stay_idle", 32'(busy), 32'(0));

        // Reset mid-run with partial results present
        gate_mode = GATE_AND;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("midrst.pre_err", 32'(err_count), 32'(1));
        check("midrst.pre_fv",  32'(fail_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check("midrst.busy",   32'(busy),   32'(0));
        check("midrst.dut_in", 32'(dut_in), 32'(0));
        check_results("midrst", 3'd0, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("midrst.done@%0d", k), 32'(done), 32'(0));
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("midrst.after_busy@%0d", k), 32'(busy), 32'(0));
            check($sformatf("midrst.after_done@%0d", k), 32'(done), 32'(0));
        end

        // HOLD_CYCLES=1: busy cycles 1-4, done in cycle 5
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("h1.busy@%0d", k),   32'(busy1),   32'(k <= 4));
            check($sformatf("h1.done@%0d", k),   32'(done1),   32'(k == 5));
            check($sformatf("h1.dut_in@%0d", k), 32'(dut_in1), (k <= 4) ? 32'(k - 1) : 32'(0));
            tick();
        end
        check("h1.pass",      32'(pass1),      32'(1));
        check("h1.err_count", 32'(err_count1), 32'(0));
        check("h1.fail_valid",32'(fail_valid1),32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
